// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot loader.
package boot_pkg;

  typedef enum logic [2:0] {
    SEND_HELLO = 3'd0,
    RECV_SIZE  = 3'd1,
    RECV_PROG  = 3'd2,
    SEND_ACK   = 3'd3,
    RUN        = 3'd4,
    ERROR      = 3'd5
  } boot_state_t;

  localparam logic [7:0] HELLO_BYTE = 8'h99;
  localparam logic [7:0] ACK_BYTE   = 8'hAA;

  // A program size is loadable when word aligned and no larger than the whole imem.
  function automatic logic size_ok(input logic [31:0] size, input int aw);
    logic [32:0] max_bytes;
    max_bytes = 33'd4 << aw;
    return (size[1:0] == 2'b00) && ({1'b0, size} <= max_bytes);
  endfunction

endpackage

// File: rtl/boot_loader_stdin_fifo.sv
// First-word-fall-through FIFO holding stdin bytes received after boot.
module stdin_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ZERO  = PTR_W'(32'd0);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(32'd1);
  localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(32'd1);
  localparam logic [PTR_W:0]   CNT_ZERO  = (PTR_W + 1)'(32'd0);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign empty_o = (count_q == CNT_ZERO);
  assign full_o  = (count_q == CNT_FULL);
  assign rdata_o = empty_o ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

  // Pointer and occupancy update; a push into a full FIFO is accepted only alongside a pop.
  always_comb begin
    do_pop_s  = pop_i && !empty_o;
    do_push_s = push_i && (!full_o || do_pop_s);
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    if (do_pop_s) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? PTR_ZERO : rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (do_push_s) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? PTR_ZERO : wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= PTR_ZERO;
      wr_ptr_q <= PTR_ZERO;
      count_q  <= CNT_ZERO;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates the output.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/boot_loader.sv
// UART boot loader: handshakes with the host, streams the program into imem,
// then forwards later bytes into the stdin FIFO.
module boot_loader
  import boot_pkg::*;
#(
  parameter int IMEM_ADDR_WIDTH  = 15,
  parameter int STDIN_FIFO_DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [7:0]                 rx_rdata,
  input  logic                       rx_rdata_ready,
  input  logic                       rx_ferr,
  output logic [7:0]                 tx_sdata,
  output logic                       tx_start,
  input  logic                       tx_busy,
  output logic                       imem_we,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]                imem_wdata,
  output logic                       boot_done,
  output logic                       boot_error,
  output logic [7:0]                 stdin_rdata,
  output logic                       stdin_empty,
  input  logic                       stdin_re,
  output logic                       stdin_overflow
);

  localparam logic [IMEM_ADDR_WIDTH-1:0] IDX_ONE = IMEM_ADDR_WIDTH'(32'd1);

  boot_state_t                state_q, state_d;
  logic [31:0]                size_q, size_d, byte_cnt_q, byte_cnt_d;
  logic [23:0]                word_q, word_d;
  logic [IMEM_ADDR_WIDTH-1:0] word_idx_q, word_idx_d, imem_addr_q, imem_addr_d;
  logic [31:0]                imem_wdata_q, imem_wdata_d;
  logic [7:0]                 tx_sdata_q, tx_sdata_d;
  logic                       tx_start_q, tx_start_d, imem_we_q, imem_we_d;
  logic                       boot_done_q, boot_done_d, boot_error_q, boot_error_d;
  logic                       overflow_q, overflow_d;
  logic                       rx_good_s, rx_bad_s, tx_ok_s, fifo_push_s, fifo_full_s;
  logic [31:0]                new_size_s;

  assign rx_good_s  = rx_rdata_ready && !rx_ferr;
  assign rx_bad_s   = rx_rdata_ready && rx_ferr;
  // The extra !tx_start_q cycle hides UART_TX's latency in raising tx_busy.
  assign tx_ok_s    = !tx_busy && !tx_start_q;
  assign new_size_s = {rx_rdata, size_q[31:8]};

  // Next-state and output decode.
  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    word_idx_d   = word_idx_q;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    tx_sdata_d   = tx_sdata_q;
    tx_start_d   = 1'b0;
    imem_we_d    = 1'b0;
    boot_done_d  = boot_done_q;
    boot_error_d = boot_error_q;
    fifo_push_s  = 1'b0;
    case (state_q)
      SEND_HELLO: begin
        if (tx_ok_s) begin
          tx_start_d = 1'b1;
          tx_sdata_d = HELLO_BYTE;
          state_d    = RECV_SIZE;
        end else begin
          state_d = SEND_HELLO;
        end
      end
      RECV_SIZE: begin
        if (rx_bad_s) begin
          state_d = ERROR;
        end else if (rx_good_s) begin
          size_d = new_size_s;
          if (byte_cnt_q == 32'd3) begin
            byte_cnt_d = 32'd0;
            if (!size_ok(new_size_s, IMEM_ADDR_WIDTH)) begin
              state_d = ERROR;
            end else if (new_size_s == 32'd0) begin
              state_d = SEND_ACK;
            end else begin
              state_d = RECV_PROG;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 32'd1;
          end
        end else begin
          state_d = RECV_SIZE;
        end
      end
      RECV_PROG: begin
        if (rx_bad_s) begin
          state_d = ERROR;
        end else if (rx_good_s) begin
          byte_cnt_d = byte_cnt_q + 32'd1;
          word_d     = {rx_rdata, word_q[23:8]};
          if (byte_cnt_q[1:0] == 2'b11) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_idx_q;
            imem_wdata_d = {rx_rdata, word_q};
            word_idx_d   = word_idx_q + IDX_ONE;
          end else begin
            imem_we_d = 1'b0;
          end
          if (byte_cnt_q + 32'd1 == size_q) begin
            state_d = SEND_ACK;
          end else begin
            state_d = RECV_PROG;
          end
        end else begin
          state_d = RECV_PROG;
        end
      end
      SEND_ACK: begin
        fifo_push_s = rx_good_s;
        if (tx_ok_s) begin
          tx_start_d = 1'b1;
          tx_sdata_d = ACK_BYTE;
          state_d    = RUN;
        end else begin
          state_d = SEND_ACK;
        end
      end
      RUN: begin
        fifo_push_s = rx_good_s;
        boot_done_d = 1'b1;
      end
      ERROR: begin
        boot_error_d = 1'b1;
      end
      default: begin
        state_d = ERROR;
      end
    endcase
    if (fifo_push_s && fifo_full_s && !stdin_re) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= SEND_HELLO;
      size_q       <= 32'd0;
      byte_cnt_q   <= 32'd0;
      word_q       <= 24'd0;
      word_idx_q   <= '0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'd0;
      imem_we_q    <= 1'b0;
      tx_sdata_q   <= 8'd0;
      tx_start_q   <= 1'b0;
      boot_done_q  <= 1'b0;
      boot_error_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      word_idx_q   <= word_idx_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      imem_we_q    <= imem_we_d;
      tx_sdata_q   <= tx_sdata_d;
      tx_start_q   <= tx_start_d;
      boot_done_q  <= boot_done_d;
      boot_error_q <= boot_error_d;
      overflow_q   <= overflow_d;
    end
  end

  stdin_fifo #(
    .WIDTH(8),
    .DEPTH(STDIN_FIFO_DEPTH)
  ) u_stdin_fifo (
    .clk    (clk),
    .rst_n  (reset_n),
    .push_i (fifo_push_s),
    .wdata_i(rx_rdata),
    .pop_i  (stdin_re),
    .rdata_o(stdin_rdata),
    .full_o (fifo_full_s),
    .empty_o(stdin_empty)
  );

  assign tx_sdata       = tx_sdata_q;
  assign tx_start       = tx_start_q;
  assign imem_we        = imem_we_q;
  assign imem_addr      = imem_addr_q;
  assign imem_wdata     = imem_wdata_q;
  assign boot_done      = boot_done_q;
  assign boot_error     = boot_error_q;
  assign stdin_overflow = overflow_q;

endmodule
